// File: rtl/sega_pad_pkg.sv
// sega_pad_pkg: shared types and indices for the SEGA pad scanner.
//   - button bit positions inside the published 12-bit vector
//   - raw pad pin positions
//   - scanner state enum
//   - NUM_PHASES: SELECT half-phases per scan. 8 when SEGA_PAD_SIX_BTN_EN
//     is defined (6-button handshake), otherwise 2 (3-button read only).
package sega_pad_pkg;

  // Published vector: {MODE,X,Y,Z,START,C,B,A,RIGHT,LEFT,DOWN,UP}
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_A     = 4;
  localparam int BTN_B     = 5;
  localparam int BTN_C     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_Z     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_X     = 10;
  localparam int BTN_MODE  = 11;

  // Raw pad pins (active-low)
  localparam int PIN_UP         = 0;
  localparam int PIN_DOWN       = 1;
  localparam int PIN_LEFT_X     = 2;
  localparam int PIN_RIGHT_MODE = 3;
  localparam int PIN_B_A        = 4;
  localparam int PIN_C_START    = 5;

`ifdef SEGA_PAD_SIX_BTN_EN
  localparam int NUM_PHASES = 8;
`else
  localparam int NUM_PHASES = 2;
`endif

  typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_t;

  typedef logic [11:0] btn_vec_t;

endpackage

// File: rtl/sega_pad_scanner_if.sv
// sega_pad_scanner_if: pad-side and register-side signals of the scanner.
//   enable      scan continuously while high
//   pad_in[5:0] raw active-low pad pins (asynchronous)
//   pad_sel     SELECT pin to the pad
//   buttons     active-high button snapshot
//   pad_present / six_button  detection results of the last scan
//   valid       one-cycle strobe when the snapshot updates
//   busy        high while scanning
// slave = scanner, master = the block driving enable / the pad pins.
interface sega_pad_scanner_if;
  import sega_pad_pkg::*;

  logic       enable;
  logic [5:0] pad_in;
  logic       pad_sel;
  btn_vec_t   buttons;
  logic       pad_present;
  logic       six_button;
  logic       valid;
  logic       busy;

  modport slave (
    input  enable, pad_in,
    output pad_sel, buttons, pad_present, six_button, valid, busy
  );

  modport master (
    output enable, pad_in,
    input  pad_sel, buttons, pad_present, six_button, valid, busy
  );
endinterface

// File: rtl/sega_pad_sync.sv
// sega_pad_sync: 6-bit two-flop synchronizer for the asynchronous pad pins.
// Resets to 6'h3F so an idle (all high) pad is seen during and after reset.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_pins         : raw pins
//   o_pins         : synchronized pins
module sega_pad_sync (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_pins,
  output logic [5:0] o_pins
);
  logic [5:0] r_meta;
  logic [5:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 6'h3F;
      r_sync <= 6'h3F;
    end else begin
      r_meta <= i_pins;
      r_sync <= r_meta;
    end
  end

  assign o_pins = r_sync;
endmodule

// File: rtl/sega_pad_scanner.sv
// sega_pad_scanner: polling sequencer for one Mega Drive/Genesis pad port.
// IDLE holds SELECT high for IDLE_CYCLES, SCAN walks SELECT through
// NUM_PHASES half-phases of PHASE_CYCLES each and samples the synchronized
// pins on the last cycle of every phase into a staging register, PUBLISH
// copies the staging register to the outputs and strobes valid.
// Build option: SEGA_PAD_SIX_BTN_EN selects the 8-phase 6-button handshake;
// without it only phases 0 and 1 run (3-button read, six_button=0).
//   ACLK, ARESETN : clock, synchronous active-low reset
//   bus (slave)   : enable, pad_in -> pad_sel, buttons, pad_present,
//                   six_button, valid, busy
module sega_pad_scanner
  import sega_pad_pkg::*;
#(
  parameter int PHASE_CYCLES = 1000,
  parameter int IDLE_CYCLES  = 200000
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  sega_pad_scanner_if.slave   bus
);

  localparam int CMAX = (IDLE_CYCLES > PHASE_CYCLES) ? IDLE_CYCLES : PHASE_CYCLES;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] IDLE_LAST  = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] PHASE_LAST = CW'(PHASE_CYCLES - 1);
  localparam logic [2:0]    PH_LAST    = 3'(NUM_PHASES - 1);

  state_t        r_state, w_nxt_state;
  logic [CW-1:0] r_cnt, w_nxt_cnt;
  logic [2:0]    r_phase, w_nxt_phase;
  logic          w_cap;
  logic          r_pad_sel;

  logic [5:0]    w_pins;
  logic [5:0]    w_act;

  btn_vec_t      r_stg_btn;
  logic          r_stg_present;
  logic          r_stg_six;

  btn_vec_t      r_buttons;
  logic          r_present;
  logic          r_six;
  logic          r_valid;

  sega_pad_sync u_sync (
    .i_clk   (ACLK),
    .i_rst_n (ARESETN),
    .i_pins  (bus.pad_in),
    .o_pins  (w_pins)
  );

  assign w_act = ~w_pins;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_phase   <= '0;
      r_pad_sel <= 1'b1;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_phase   <= w_nxt_phase;
      // Registered from next state so the pad pin never glitches.
      r_pad_sel <= !((w_nxt_state == SCAN) && w_nxt_phase[0]);
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_phase = r_phase;
    w_cap       = 1'b0;
    case (r_state)
      IDLE: begin
        // Counter saturates at the end of the wait while enable is low,
        // so a late enable starts the scan on its first cycle.
        if (r_cnt == IDLE_LAST) begin
          if (bus.enable) begin
            w_nxt_state = SCAN;
            w_nxt_cnt   = '0;
            w_nxt_phase = '0;
          end
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      SCAN: begin
        if (r_cnt == PHASE_LAST) begin
          w_cap     = 1'b1;
          w_nxt_cnt = '0;
          if (r_phase == PH_LAST) w_nxt_state = PUBLISH;
          else                    w_nxt_phase = r_phase + 1'b1;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      PUBLISH: begin
        w_nxt_state = IDLE;
        w_nxt_cnt   = '0;
        w_nxt_phase = '0;
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_cnt   = '0;
        w_nxt_phase = '0;
      end
    endcase
  end

  // Staging register: cleared while idle so nothing leaks between scans.
  always_ff @(posedge ACLK) begin
    if (!ARESETN || (r_state == IDLE)) begin
      r_stg_btn     <= '0;
      r_stg_present <= 1'b0;
      r_stg_six     <= 1'b0;
    end else if (w_cap) begin
      case (r_phase)
        3'd0: begin
          r_stg_btn[BTN_UP]    <= w_act[PIN_UP];
          r_stg_btn[BTN_DOWN]  <= w_act[PIN_DOWN];
          r_stg_btn[BTN_LEFT]  <= w_act[PIN_LEFT_X];
          r_stg_btn[BTN_RIGHT] <= w_act[PIN_RIGHT_MODE];
          r_stg_btn[BTN_B]     <= w_act[PIN_B_A];
          r_stg_btn[BTN_C]     <= w_act[PIN_C_START];
        end
        3'd1: begin
          r_stg_btn[BTN_A]     <= w_act[PIN_B_A];
          r_stg_btn[BTN_START] <= w_act[PIN_C_START];
          // A real pad grounds LEFT/RIGHT while SELECT is low.
          r_stg_present        <= (w_pins[3:2] == 2'b00);
        end
`ifdef SEGA_PAD_SIX_BTN_EN
        3'd5: begin
          // Third low phase: a 6-button pad grounds all four d-pad pins.
          r_stg_six <= (w_pins[3:0] == 4'b0000);
        end
        3'd6: begin
          if (r_stg_six) begin
            r_stg_btn[BTN_Z]    <= w_act[PIN_UP];
            r_stg_btn[BTN_Y]    <= w_act[PIN_DOWN];
            r_stg_btn[BTN_X]    <= w_act[PIN_LEFT_X];
            r_stg_btn[BTN_MODE] <= w_act[PIN_RIGHT_MODE];
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_buttons <= '0;
      r_present <= 1'b0;
      r_six     <= 1'b0;
      r_valid   <= 1'b0;
    end else if (r_state == PUBLISH) begin
      r_buttons <= r_stg_present ? r_stg_btn : '0;
      r_present <= r_stg_present;
      r_six     <= r_stg_present & r_stg_six;
      r_valid   <= 1'b1;
    end else begin
      r_valid   <= 1'b0;
    end
  end

  assign bus.pad_sel     = r_pad_sel;
  assign bus.buttons     = r_buttons;
  assign bus.pad_present = r_present;
  assign bus.six_button  = r_six;
  assign bus.valid       = r_valid;
  assign bus.busy        = (r_state == SCAN);

endmodule

// File: tb/tb_sega_pad_scanner.sv
// tb_sega_pad_scanner: directed bench for sega_pad_scanner with a behavioural
// pad (3- or 6-button) that counts SELECT falling edges and resets its
// counter after a long SELECT-high period, like the real controller.
module tb_sega_pad_scanner;
  localparam int PC = 8;
  localparam int IC = 32;
`ifdef SEGA_PAD_SIX_BTN_EN
  localparam int NPH = 8, RST_PH = 4, DROP_PH = 2, SIXV = 1;
`else
  localparam int NPH = 2, RST_PH = 1, DROP_PH = 1, SIXV = 0;
`endif
  localparam int SCANLEN = NPH * PC;
  localparam int PER     = IC + SCANLEN + 1;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  sega_pad_scanner_if bus ();

  sega_pad_scanner #(.PHASE_CYCLES(PC), .IDLE_CYCLES(IC)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  // ---------------- pad model ----------------
  logic        pad_conn = 1'b0;
  logic        pad_six  = 1'b0;
  logic [11:0] held     = 12'h000;
  logic        sel_q    = 1'b1;
  int          hi_cnt   = 0;
  int          falls    = 0;

  always @(posedge ACLK) begin
    sel_q <= bus.pad_sel;
    if (!bus.pad_sel) hi_cnt <= 0;
    else if (hi_cnt < 100) hi_cnt <= hi_cnt + 1;
    if (sel_q && !bus.pad_sel) falls <= (hi_cnt >= 20) ? 1 : falls + 1;
    else if (hi_cnt >= 20)     falls <= 0;
  end

  function automatic logic [5:0] pad_pins(input logic sel, input int f,
                                          input logic six, input logic [11:0] h);
    logic [5:0] p;  // pressed / grounded, active-high
    if (sel) begin
      if (six && f == 3) p = {h[6], h[5], h[11], h[10], h[9], h[8]};
      else               p = {h[6], h[5], h[3], h[2], h[1], h[0]};
    end else begin
      if (six && f == 3) p = {h[7], h[4], 4'b1111};
      else               p = {h[7], h[4], 2'b11, h[1], h[0]};
    end
    return ~p;
  endfunction

  assign bus.pad_in = pad_conn ? pad_pins(bus.pad_sel, falls, pad_six, held) : 6'h3F;

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int n, output int nb);
    n = 0; nb = 0;
    do begin
      @(negedge ACLK);
      n++;
      if (bus.busy) nb++;
    end while (!bus.valid && n < 1000);
  endtask

  task automatic wait_busy();
    int k = 0;
    while (!bus.busy && k < 400) begin
      @(negedge ACLK);
      k++;
    end
    check("busy_seen", bus.busy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, nb, nv, nsel, nbusy;
    bus.enable = 1'b1;
    repeat (3) @(negedge ACLK);
    check("rst_pad_sel", bus.pad_sel, 1);
    check("rst_buttons", bus.buttons, 0);
    check("rst_present", bus.pad_present, 0);
    check("rst_six", bus.six_button, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_busy", bus.busy, 0);

    // No pad
    ARESETN = 1'b1;
    wait_valid(n, nb);
    check("first_latency", n, PER);
    check("first_busy_len", nb, SCANLEN);
    check("nopad_present", bus.pad_present, 0);
    check("nopad_buttons", bus.buttons, 0);
    @(negedge ACLK);
    check("valid_width", bus.valid, 0);
    wait_valid(n, nb);
    check("period", n, PER - 1);
    check("busy_len", nb, SCANLEN);

    // 3-button pad, A+RIGHT
    pad_conn = 1'b1; pad_six = 1'b0; held = 12'h018;
    wait_valid(n, nb);
    check("p3_present", bus.pad_present, 1);
    check("p3_six", bus.six_button, 0);
    check("p3_buttons", bus.buttons, 12'h018);

    // 3-button pad, all eight buttons
    held = 12'h0FF;
    wait_valid(n, nb);
    check("p3all_buttons", bus.buttons, 12'h0FF);

    // 6-button pad, UP+Z+MODE
    pad_six = 1'b1; held = 12'h901;
    wait_valid(n, nb);
    check("p6_present", bus.pad_present, 1);
    check("p6_six", bus.six_button, SIXV);
    check("p6_buttons", bus.buttons, SIXV ? 12'h901 : 12'h001);

    // 6-button pad, Z only
    held = 12'h100;
    wait_valid(n, nb);
    check("p6z_buttons", bus.buttons, SIXV ? 12'h100 : 12'h000);
    check("p6z_busy_len", nb, SCANLEN);

    // 6-button pad, everything
    held = 12'hFFF;
    wait_valid(n, nb);
    check("p6all_buttons", bus.buttons, SIXV ? 12'hFFF : 12'h0FF);

    // Reset in the middle of a scan
    wait_busy();
    repeat (RST_PH * PC + 3) @(negedge ACLK);
    check("pre_rst_sel", bus.pad_sel, (RST_PH % 2) ? 0 : 1);
    ARESETN = 1'b0;
    @(negedge ACLK);
    check("mid_rst_sel", bus.pad_sel, 1);
    check("mid_rst_buttons", bus.buttons, 0);
    check("mid_rst_present", bus.pad_present, 0);
    check("mid_rst_six", bus.six_button, 0);
    check("mid_rst_busy", bus.busy, 0);
    ARESETN = 1'b1;
    wait_valid(n, nb);
    check("post_rst_latency", n, PER);
    check("post_rst_buttons", bus.buttons, SIXV ? 12'hFFF : 12'h0FF);

    // enable dropped mid-scan
    wait_busy();
    repeat (DROP_PH * PC + 3) @(negedge ACLK);
    bus.enable = 1'b0;
    wait_valid(n, nb);
    check("drop_valid", bus.valid, 1);
    check("drop_buttons", bus.buttons, SIXV ? 12'hFFF : 12'h0FF);
    nv = 0; nsel = 0; nbusy = 0;
    repeat (3 * PER) begin
      @(negedge ACLK);
      if (bus.valid)    nv++;
      if (!bus.pad_sel) nsel++;
      if (bus.busy)     nbusy++;
    end
    check("drop_no_valid", nv, 0);
    check("drop_sel_high", nsel, 0);
    check("drop_no_busy", nbusy, 0);
    bus.enable = 1'b1;
    @(negedge ACLK);
    check("reenable_busy", bus.busy, 1);
    wait_valid(n, nb);
    check("reenable_latency", n, SCANLEN + 1);
    check("reenable_busy_len", nb, SCANLEN - 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
